// File: rtl/mips32_dbg_pkg.sv
// Shared debug-path definitions for the MIPS32 core: dump FSM encodings,
// beat tag values and the default register-file / memory geometry used by
// the core, the state-dump engine and the program loader.
package mips32_dbg_pkg;

   localparam int DEF_NREGS = 32;
   localparam int DEF_MAW   = 10;

   localparam logic TAG_REG = 1'b0;
   localparam logic TAG_MEM = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_CAPT = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } dump_state_t;

endpackage

// File: rtl/mips32_state_dump.sv
// Post-halt readout: walks the register file, then a memory window, one tagged beat per word.
// Latency: trigger edge E0 -> out_valid after E2; one beat per 3 cycles with out_ready high.
// Backpressure: a presented beat holds all out_* fields until out_valid & out_ready.
module mips32_state_dump
   import mips32_dbg_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int RAW   = 5,
   parameter int DW    = 32,
   parameter int MAW   = DEF_MAW
) (
   input  logic           clk1,
   input  logic           rst_n,
   input  logic           halted,
   output logic [RAW-1:0] reg_raddr,
   input  logic [DW-1:0]  reg_rdata,
   output logic [MAW-1:0] mem_raddr,
   input  logic [DW-1:0]  mem_rdata,
   input  logic [MAW-1:0] mem_base,
   input  logic [MAW:0]   mem_len,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_tag,
   output logic [MAW-1:0] out_index,
   output logic [DW-1:0]  out_data,
   output logic           out_last,
   output logic           busy,
   output logic           done
);

   localparam logic [MAW-1:0] LAST_REG = MAW'(NREGS - 1);
   localparam logic [MAW:0]   ONE_LEN  = (MAW+1)'(1);

   dump_state_t    state, state_nx;
   logic           halted_q;
   logic           trigger;
   logic           hs;
   logic           tag;
   logic [MAW-1:0] idx;
   logic [MAW-1:0] base_l;
   logic [MAW:0]   len_l;
   logic           last_cur;
   logic [MAW-1:0] idx_adv;
   logic           tag_adv;

   // Rising edge of HALTED; only acted on from IDLE.
   assign trigger = halted & ~halted_q;
   assign hs      = out_valid & out_ready;

   // Last beat is the final register when no memory window, else memory word len_l-1.
   assign last_cur = (tag == TAG_REG) ? ((idx == LAST_REG) && (len_l == '0))
                                      : ({1'b0, idx} == (len_l - ONE_LEN));

   // Step to the next word; the register walk rolls over into the memory walk.
   assign tag_adv = (tag == TAG_REG && idx == LAST_REG) ? TAG_MEM : tag;
   assign idx_adv = (tag == TAG_REG && idx == LAST_REG) ? '0 : idx + 1'b1;

   // State register.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: WAIT covers the read latency, CAPT captures, SEND holds for the sink.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (trigger)  state_nx = ST_WAIT;
         ST_WAIT:               state_nx = ST_CAPT;
         ST_CAPT:               state_nx = ST_SEND;
         ST_SEND: if (hs)       state_nx = out_last ? ST_DONE : ST_WAIT;
         ST_DONE: if (!halted)  state_nx = ST_IDLE;
         default:               state_nx = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         ST_WAIT, ST_CAPT, ST_SEND: busy = 1'b1;
         ST_DONE:                   done = 1'b1;
         default: ;
      endcase
   end

   // Walk counters, read addresses and the output beat register.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         halted_q  <= 1'b0;
         tag       <= TAG_REG;
         idx       <= '0;
         base_l    <= '0;
         len_l     <= '0;
         reg_raddr <= '0;
         mem_raddr <= '0;
         out_valid <= 1'b0;
         out_tag   <= 1'b0;
         out_index <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         halted_q <= halted;
         unique case (state)
            ST_IDLE: begin
               if (trigger) begin
                  base_l    <= mem_base;
                  len_l     <= mem_len;
                  tag       <= TAG_REG;
                  idx       <= '0;
                  reg_raddr <= '0;
                  mem_raddr <= mem_base;
               end
            end
            ST_CAPT: begin
               out_valid <= 1'b1;
               out_tag   <= tag;
               out_index <= (tag == TAG_MEM) ? mem_raddr : idx;
               out_data  <= (tag == TAG_MEM) ? mem_rdata : reg_rdata;
               out_last  <= last_cur;
            end
            ST_SEND: begin
               if (hs) begin
                  out_valid <= 1'b0;
                  if (!out_last) begin
                     tag       <= tag_adv;
                     idx       <= idx_adv;
                     reg_raddr <= idx_adv[RAW-1:0];
                     mem_raddr <= base_l + idx_adv;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_state_dump.sv
// Directed bench for mips32_state_dump: register file and memory models with
// 1-cycle synchronous reads, beat-by-beat checks of tag/index/data/last and timing.
module tb_mips32_state_dump;

   localparam int NREGS = 32;

   logic        clk1 = 1'b0;
   logic        rst_n;
   logic        halted;
   logic [4:0]  reg_raddr;
   logic [31:0] reg_rdata;
   logic [9:0]  mem_raddr;
   logic [31:0] mem_rdata;
   logic [9:0]  mem_base;
   logic [10:0] mem_len;
   logic        out_valid;
   logic        out_ready;
   logic        out_tag;
   logic [9:0]  out_index;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;

   logic [31:0] rf  [0:31];
   logic [31:0] mem [0:1023];
   logic [31:0] prog [0:8];

   mips32_state_dump dut (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .halted    (halted),
      .reg_raddr (reg_raddr),
      .reg_rdata (reg_rdata),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_base  (mem_base),
      .mem_len   (mem_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tag   (out_tag),
      .out_index (out_index),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk1 = ~clk1;

   always @(posedge clk1) begin
      cyc       <= cyc + 1;
      reg_rdata <= rf[reg_raddr];
      mem_rdata <= mem[mem_raddr];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Consume one dump starting at the next rising edge (the trigger edge).
   // stall_beat: beat held off for 5 cycles; abort_beat: return with that beat presented.
   task automatic run_dump(input int nmem, input logic [9:0] base,
                           input int stall_beat, input int abort_beat);
      int          cyc0;
      int          prev;
      int          total;
      logic [9:0]  off;
      logic [9:0]  ei;
      logic [31:0] ed;
      logic        et;
      logic        el;
      total = NREGS + nmem;
      prev  = 0;
      @(posedge clk1);
      #1 cyc0 = cyc;
      for (int b = 0; b < total; b++) begin
         et = (b >= NREGS);
         off = 10'(b - NREGS);
         ei = et ? base + off : 10'(b);
         ed = et ? mem[ei] : rf[b[4:0]];
         el = (b == total - 1);
         @(negedge clk1);
         for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk1);
         check("beat_valid", out_valid, 1'b1);
         if (!out_valid) return;
         if (b == 0) check("first_latency", cyc - cyc0, 2);
         else if (stall_beat < 0) check("beat_spacing", cyc - prev, 3);
         prev = cyc;
         check("beat_tag", out_tag, et);
         check("beat_index", out_index, ei);
         check("beat_data", out_data, ed);
         check("beat_last", out_last, el);
         check("beat_busy", busy, 1'b1);
         if (b == abort_beat) return;
         if (b == stall_beat) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk1);
               check("stall_valid", out_valid, 1'b1);
               check("stall_index", out_index, ei);
               check("stall_data", out_data, ed);
            end
            out_ready = 1'b1;
         end
         @(posedge clk1);
      end
      @(negedge clk1);
      check("end_done", done, 1'b1);
      check("end_busy", busy, 1'b0);
      check("end_valid", out_valid, 1'b0);
      if (stall_beat < 0) check("total_cycles", cyc - cyc0, 3 * total);
   endtask

   // Drop halted for one cycle (DONE -> IDLE), then re-arm with a new window.
   task automatic rearm(input logic [9:0] base, input logic [10:0] len);
      halted = 1'b0;
      @(negedge clk1);
      @(negedge clk1);
      check("rearm_done", done, 1'b0);
      check("rearm_busy", busy, 1'b0);
      mem_base = base;
      mem_len  = len;
      halted   = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h00221800;
      prog[3] = 32'h00222000; prog[4] = 32'h00222800; prog[5] = 32'hac030000;
      prog[6] = 32'h8c040000; prog[7] = 32'h00000000; prog[8] = 32'hfc000000;
      for (int k = 0; k < 32; k++) rf[k] = 32'(k);
      for (int a = 0; a < 1024; a++) mem[a] = 32'h5a000000 | 32'(a);
      for (int a = 0; a < 9; a++) mem[a] = prog[a];
      mem[1022] = 32'hdead0ffe;
      mem[1023] = 32'hdead0fff;

      rst_n = 1'b1; halted = 1'b0; out_ready = 1'b1;
      mem_base = '0; mem_len = '0;

      // Asynchronous reset mid-cycle clears everything at once.
      #13 rst_n = 1'b0;
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      check("rst_tag", out_tag, 1'b0);
      check("rst_index", out_index, 10'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_reg_raddr", reg_raddr, 5'd0);
      check("rst_mem_raddr", mem_raddr, 10'd0);
      @(negedge clk1);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk1);
         if (out_valid || busy) seen++;
      end
      check("idle_no_beats", seen, 0);

      // Register-only dump.
      halted = 1'b1;
      run_dump(0, 10'd0, -1, -1);

      // halted held high after completion must not restart.
      seen = 0;
      repeat (30) begin
         @(negedge clk1);
         if (out_valid || busy) seen++;
      end
      check("hold_no_redump", seen, 0);
      check("hold_done", done, 1'b1);

      // Re-arm: registers plus program window, with backpressure on beat 4.
      rearm(10'd0, 11'd9);
      run_dump(9, 10'd0, 4, -1);

      // Window wrapping past the top of the address space.
      rearm(10'd1022, 11'd4);
      run_dump(4, 10'd1022, -1, -1);

      // Reset while beat 10 is presented, then a fresh dump with halted still high.
      rearm(10'd0, 11'd0);
      run_dump(0, 10'd0, -1, 10);
      rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_index", out_index, 10'd0);
      @(negedge clk1);
      rst_n = 1'b1;
      run_dump(0, 10'd0, -1, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mips32_state_dump.md
# mips32_state_dump

Post-halt architectural-state readout engine for the pipelined MIPS32 core. When the core's HALTED flag rises, the block walks the register file, then a programmable instruction/data memory window. It streams each word out over a valid/ready interface as a tagged, indexed beat. It is the read-side counterpart to program loading, and replaces hierarchical peeks at register and memory contents with a synthesizable, bench- and host-visible stream.

## Interface
- NREGS, 32, number of registers dumped (indices 0..NREGS-1)
- RAW, 5, register read-address width
- DW, 32, data width
- MAW, 10, memory read-address width (word addressed)
- clk1  in  1  single clock (core phase-1 clock)
- rst_n  in  1  asynchronous, active-low reset
- halted  in  1  core HALTED flag
- reg_raddr  out  RAW  register-file read address (synchronous read, 1-cycle latency)
- reg_rdata  in  DW  register-file read data
- mem_raddr  out  MAW  memory read address (synchronous read, 1-cycle latency)
- mem_rdata  in  DW  memory read data
- mem_base  in  MAW  first memory word of the window, sampled at trigger
- mem_len  in  MAW+1  window length in words, sampled at trigger, 0 = no memory dump
- out_valid  out  1  beat valid
- out_ready  in  1  sink ready
- out_tag  out  1  0 = register beat, 1 = memory beat
- out_index  out  MAW  register index, or memory address actually read
- out_data  out  DW  word
- out_last  out  1  final beat of the dump
- busy  out  1  dump in progress
- done  out  1  dump complete, held until halted falls

## Operation
- States: IDLE, WAIT, CAPT, SEND, DONE.
- Trigger: halted==1 while the registered copy halted_q==0. halted_q resets to 0, so halted high out of reset triggers a dump.
- On trigger:
  - Latch mem_base and mem_len.
  - Set idx=0 and tag=0.
  - Go to WAIT.
- Read addresses are registered and held stable through WAIT, CAPT and SEND:
  - reg_raddr = idx[RAW-1:0]
  - mem_raddr = (base_l + idx) mod 2^MAW, wrapping silently
- State transitions:
  - WAIT → CAPT unconditionally.
  - CAPT → SEND. On this edge: out_data ← selected rdata, out_tag, out_index, out_last, out_valid ← 1.
  - SEND, on out_valid & out_ready: out_valid ← 0, then:
    - If out_last → DONE.
    - Else if tag=0 and idx=NREGS-1 → tag=1, idx=0, WAIT.
    - Else idx+1 → WAIT.
- out_last rules:
  - Set on register NREGS-1 when len_l==0.
  - Otherwise set on memory beat len_l-1.
- DONE: done=1. Return to IDLE when halted==0. halted held high never re-triggers.
- IDLE: busy=0, done=0. busy=1 in WAIT, CAPT and SEND.
- halted falling mid-dump is ignored; the dump runs to completion, then DONE exits to IDLE on the next cycle.
- halted toggling during a dump: the trigger is only evaluated in IDLE.

## Timing
- Reset (async, immediate) clears:
  - state=IDLE
  - out_valid, out_last, out_tag, busy, done all 0
  - out_index, out_data, reg_raddr, mem_raddr all 0
  - halted_q=0
- Reset mid-dump abandons it. No partial beat appears after rst_n deasserts.
- Latency: trigger edge E0 → out_valid high after E2.
- Cadence with out_ready held high: one beat every 3 cycles, valid high 1 cycle each.
- Total dump with ready high: 3·(NREGS+len_l) cycles from E0 to the last handshake edge. done rises on that edge.
- AXI-stream rule: once out_valid=1, all out_* fields are stable until the handshake. out_valid never drops without a handshake, except on reset.
- out_ready is ignored when out_valid=0.

## Structure
- Shared package / include mips32_dbg_pkg holds:
  - state encodings
  - TAG_REG=0 and TAG_MEM=1
  - default NREGS and MAW constants, shared with the core and the future loader
- Single flat module. No sub-module is warranted.
- The trigger detector stays inline as one flop plus a gate.

## Test plan
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately. Release with halted=0 → no beats for 20 cycles.
- Register dump:
  - Setup: Reg[k]=k, mem_len=0, out_ready=1, halted 0→1.
  - 32 beats, tag=0, index/data 0..31, out_last only on 31.
  - First valid 2 cycles after trigger edge; beats spaced 3 cycles.
  - done=1 after the final beat.
- Memory window: Mem[0..8]=program words, mem_base=0, mem_len=9 → 32 register beats, then 9 tag=1 beats with data 0x2801000a…0xfc000000, out_last on address 8.
- Backpressure: drop out_ready for 5 cycles on beat 4 → out_valid, out_index=4, out_data=4 held constant, no beat lost or duplicated.
- Wrap: mem_base=1022, mem_len=4 → memory indices 1022, 1023, 0, 1.
- Re-arm and reset mid-dump:
  - halted held high after done → no second dump.
  - halted 1→0→1 → a full second dump.
  - rst_n pulsed during beat 10 → out_valid=0. With halted still high after release, a fresh dump restarts at index 0.
